// File: rtl/inj_packet_mux.sv
// N_SRC-to-1 credit-based flit concentrator with per-source FIFOs and packet-atomic round-robin.
// Optional INJ_MUX_STATS_EN adds per-source packet counters and an output stall counter.
module inj_packet_mux #(
    parameter int unsigned N_SRC     = 2,
    parameter int unsigned FLIT_SIZE = 32,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SRC-1:0]           src_rx_i,
    output logic [N_SRC-1:0]           src_credit_o,
    input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
    output logic                       tx_o,
    input  logic                       credit_i,
    output logic [FLIT_SIZE-1:0]       data_o,
    output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] grant_o,
    output logic                       busy_o
`ifdef INJ_MUX_STATS_EN
    ,
    output logic [N_SRC*16-1:0]        pkt_cnt_o,
    output logic [31:0]                stall_cnt_o
`endif
);

    localparam int unsigned GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_SIZE, S_PAYLOAD} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          rr_q, rr_d;
    logic [FLIT_SIZE-1:0]   rem_q, rem_d;
    logic                   pkt_end;
    logic                   xfer;
    logic [N_SRC-1:0]       empty;
    logic [FLIT_SIZE-1:0]   head [N_SRC];
    logic                   found_c;
    logic [GW-1:0]          pick_c;
    logic [GW-1:0]          cand_c;

    assign busy_o  = (state_q != S_IDLE);
    assign grant_o = grant_q;
    assign tx_o    = busy_o && !empty[grant_q];
    assign data_o  = tx_o ? head[grant_q] : '0;
    assign xfer    = tx_o && credit_i;

    // Per-source FIFO; credit is registered from the next occupancy so it is exact each cycle
    for (genvar k = 0; k < N_SRC; k++) begin : g_fifo
        logic [FLIT_SIZE-1:0] mem_q [BUF_DEPTH];
        logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
        logic [CW-1:0]        cnt_q, cnt_d;
        logic                 credit_q;
        logic                 push, pop;

        assign push            = src_rx_i[k] && credit_q;
        assign pop             = xfer && (grant_q == GW'(k));
        assign cnt_d           = cnt_q + CW'(push) - CW'(pop);
        assign empty[k]        = (cnt_q == '0);
        assign head[k]         = mem_q[rd_ptr_q];
        assign src_credit_o[k] = credit_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
                credit_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                cnt_q    <= cnt_d;
                credit_q <= (cnt_d != CW'(BUF_DEPTH));
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q] <= src_data_i[k*FLIT_SIZE +: FLIT_SIZE];
        end
    end

    // First non-empty source at or after the round-robin pointer
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        cand_c  = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            cand_c = GW'((32'(rr_q) + i) % N_SRC);
            if (!found_c && !empty[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        pkt_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    grant_d = pick_c;
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (xfer) state_d = S_SIZE;
            end
            S_SIZE: begin
                if (xfer) begin
                    rem_d = data_o;
                    if (data_o == '0) pkt_end = 1'b1;
                    else              state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    rem_d = rem_q - FLIT_SIZE'(1);
                    if (rem_q == FLIT_SIZE'(1)) pkt_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pkt_end) begin
            state_d = S_IDLE;
            rr_d    = (grant_q == GW'(N_SRC - 1)) ? '0 : grant_q + GW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
        end
    end

`ifdef INJ_MUX_STATS_EN
    logic [N_SRC-1:0][15:0] pkt_cnt_q;
    logic [31:0]            stall_cnt_q;

    assign pkt_cnt_o   = pkt_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

    // Packet counters wrap; the stall counter saturates
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pkt_end) pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 16'd1;
            if (tx_o && !credit_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
